pb_input_port: RTL and testbench

- Input-side counterpart to the CPU's LED output port. It turns the raw active-low push buttons into a 32-bit status word for the simple_cpu port_in bus.
- Per button: 2-FF synchronise, debounce with a 4-state FSM, count presses, latch sticky press flags.
- The CPU clears flags through a strobe decoded from its output port.

---
 rtl/pb_input_pkg.sv | 26 ++
 rtl/pb_input_port_debounce.sv | 76 +++++++
 rtl/pb_input_port.sv | 117 +++++++++++
 tb/tb_pb_input_port.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pb_input_pkg.sv
// pb_input_pkg: shared definitions for the push-button input port.
// Holds the debounce FSM state encoding, the button count and the
// bit-field offsets of the 32-bit status word read by the CPU.
package pb_input_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } pb_state_t;

  localparam int NUM_PB    = 4;
  localparam int COUNT_W   = 4;

  localparam int LEVEL_LSB = 0;
  localparam int FLAG_LSB  = 4;
  localparam int COUNT_LSB = 8;
  localparam int LONG_LSB  = 24;

  // A button counts as down while it is held or while its release is still being confirmed
  function automatic logic is_down(input pb_state_t s);
    return (s == HELD) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/pb_input_port_debounce.sv
// pb_debounce: synchroniser, 4-state debounce FSM and stability counter
// for one active-low push button. level is a pure state decode and
// press_evt pulses during the cycle whose closing edge enters HELD, so
// registers in the parent update on the same edge the level rises.
module pb_debounce
  import pb_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_n,
  output logic level,
  output logic press_evt
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           sync;
  logic                 raw;
  pb_state_t            state;
  logic [CNT_WIDTH-1:0] cnt;

  // Two-stage synchroniser; resets to the released (high) level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], pb_n};
  end

  assign raw = ~sync[1];

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (raw) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!raw) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == CNT_LAST) state <= HELD;
          end
        end
        HELD: begin
          if (!raw) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          if (raw) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == CNT_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press_evt = (state == PRESS_CHK) && raw && (cnt == CNT_LAST);
  assign level     = is_down(state);

endmodule

// File: rtl/pb_input_port.sv
// pb_input_port: turns four raw active-low push buttons into the 32-bit
// status word on the CPU's port_in bus: debounced levels, sticky press
// flags, 4-bit wrapping press counters and (optionally) long-press flags.
// Optional feature macro: PB_INPUT_PORT_LONG_PRESS_EN enables the per-button
// hold counters and long-press flags in [27:24]; without it those bits are 0.
module pb_input_port
  import pb_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb_n,
  input  logic              clear,
  input  logic [NUM_PB-1:0] clear_mask,
  output logic [31:0]       port_in
);

  logic [NUM_PB-1:0]              level;
  logic [NUM_PB-1:0]              press_evt;
  logic [NUM_PB-1:0]              flag;
  logic [NUM_PB-1:0][COUNT_W-1:0] press_cnt;
  logic [NUM_PB-1:0]              long_flag;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .pb_n     (pb_n[g]),
      .level    (level[g]),
      .press_evt(press_evt[g])
    );
  end

  // Sticky press flags: a new press beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag <= '0;
    end else begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (press_evt[i])                     flag[i] <= 1'b1;
        else if (clear && clear_mask[i])      flag[i] <= 1'b0;
      end
    end
  end

  // Press counters wrap at 16 and only reset clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (press_evt[i]) press_cnt[i] <= press_cnt[i] + COUNT_W'(1);
      end
    end
  end

`ifdef PB_INPUT_PORT_LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [NUM_PB-1:0][HOLD_W-1:0] hold_cnt;
  logic [NUM_PB-1:0]             long_evt;

  // The long event fires on the single edge where the hold count reaches its limit
  always_comb begin
    long_evt = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      long_evt[i] = level[i] && (hold_cnt[i] == HOLD_LAST);
    end
  end

  // Hold counters run while the button is down, saturate, and zero once it is back in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (!level[i])                  hold_cnt[i] <= '0;
        else if (hold_cnt[i] != HOLD_MAX) hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
      end
    end
  end

  // Sticky long-press flags with the same set-wins clear rule as the press flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_flag <= '0;
    end else begin
      for (int i = 0; i < NUM_PB; i++) begin
        if (long_evt[i])                 long_flag[i] <= 1'b1;
        else if (clear && clear_mask[i]) long_flag[i] <= 1'b0;
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = |LONG_CYCLES;
  assign long_flag       = '0;
`endif

  // Status word packing; every field is a register or a state decode
  always_comb begin
    port_in                                    = '0;
    port_in[LEVEL_LSB +: NUM_PB]               = level;
    port_in[FLAG_LSB  +: NUM_PB]               = flag;
    port_in[COUNT_LSB +: NUM_PB*COUNT_W]       = press_cnt;
    port_in[LONG_LSB  +: NUM_PB]               = long_flag;
  end

endmodule

// File: tb/tb_pb_input_port.sv
// tb_pb_input_port: scoreboard bench for pb_input_port with short debounce
// (8 cycles) and long-press (40 cycles) settings. Expected status-word
// fields are queued with the cycle they are due and compared on the
// falling clock edge of that cycle.
module tb_pb_input_port;

  localparam int DEB  = 8;
  localparam int LONG = 40;
  localparam int LAT  = DEB + 3;

`ifdef PB_INPUT_PORT_LONG_PRESS_EN
  localparam logic [31:0] LONG_EXP = 32'h0100_0000;
`else
  localparam logic [31:0] LONG_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pb_n = 4'hF;
  logic        clear = 1'b0;
  logic [3:0]  clear_mask = 4'h0;
  logic [31:0] port_in;

  int cyc = 0;
  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int          due;
    logic [31:0] mask;
    logic [31:0] value;
    string       tag;
  } exp_t;

  exp_t expQ[$];

  pb_input_port #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (4),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pb_n      (pb_n),
    .clear     (clear),
    .clear_mask(clear_mask),
    .port_in   (port_in)
  );

  always #5 clk = ~clk;

  // Count rising edges so expectations can be scheduled by cycle number
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int due, input logic [31:0] mask, input logic [31:0] value, input string tag);
    exp_t e;
    e.due   = due;
    e.mask  = mask;
    e.value = value;
    e.tag   = tag;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pop and compare every expectation that has come due by this falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    while (expQ.size() > 0 && expQ[0].due <= cyc) begin
      e = expQ.pop_front();
      checkOutput(e.tag, port_in & e.mask, e.value);
    end
  end

  task automatic applyStimulus();
    int n;

    // Reset state
    waitCycles(3);
    checkOutput("reset_state", port_in, 32'h0);
    reset = 1'b0;
    waitCycles(3);
    checkOutput("idle_after_reset", port_in, 32'h0);

    // Button 0 press and release with exact latency
    pb_n[0] = 1'b0;
    n = cyc;
    pushExp(n + LAT - 1, 32'h0F00_0F11, 32'h0000_0000, "b0_press_early");
    pushExp(n + LAT,     32'h0F00_0F11, 32'h0000_0111, "b0_press");
    waitCycles(14);
    pb_n[0] = 1'b1;
    n = cyc;
    pushExp(n + LAT - 1, 32'h0F00_0F11, 32'h0000_0111, "b0_release_early");
    pushExp(n + LAT,     32'h0F00_0F11, 32'h0000_0110, "b0_release");
    waitCycles(14);

    // Button 1 glitches shorter than the debounce window
    for (int k = 0; k < 10; k++) begin
      pb_n[1] = 1'b0;
      waitCycles(5);
      pb_n[1] = 1'b1;
      pushExp(cyc + 8, 32'h0000_F022, 32'h0, "b1_glitch");
      waitCycles(2);
    end
    waitCycles(20);

    // Button 2 pressed sixteen times; counter wraps to 0
    for (int k = 1; k <= 16; k++) begin
      pb_n[2] = 1'b0;
      n = cyc;
      pushExp(n + LAT, 32'h000F_0040, (32'(k % 16) << 16) | 32'h40, "b2_count");
      waitCycles(14);
      pb_n[2] = 1'b1;
      waitCycles(14);
    end

    // Clear only button 2's flag; counters untouched
    clear = 1'b1;
    clear_mask = 4'b0100;
    pushExp(cyc + 1, 32'h000F_FFF0, 32'h0000_0110, "clear_b2");
    waitCycles(1);
    clear = 1'b0;
    clear_mask = 4'h0;
    waitCycles(3);

    // Clear all in the exact cycle button 3 enters HELD: set wins
    pb_n[3] = 1'b0;
    n = cyc;
    waitCycles(LAT - 1);
    clear = 1'b1;
    clear_mask = 4'hF;
    pushExp(n + LAT, 32'h00FF_FFFF, 32'h0010_0188, "set_wins");
    waitCycles(1);
    clear = 1'b0;
    clear_mask = 4'h0;
    waitCycles(3);
    pb_n[3] = 1'b1;
    waitCycles(14);

    // Long hold on button 0
    pb_n[0] = 1'b0;
    n = cyc;
    pushExp(n + LAT + LONG - 1, 32'h0F00_0000, 32'h0,    "long_early");
    pushExp(n + LAT + LONG,     32'h0F00_0000, LONG_EXP, "long_set");
    pushExp(n + LAT + LONG + 8, 32'h0F00_0000, LONG_EXP, "long_hold");
    waitCycles(62);
    pb_n[0] = 1'b1;
    n = cyc;
    pushExp(n + LAT, 32'h0F00_0F11, LONG_EXP | 32'h0000_0210, "long_release");
    waitCycles(14);
    clear = 1'b1;
    clear_mask = 4'b0001;
    pushExp(cyc + 1, 32'h0F00_00F0, 32'h0000_0080, "clear_long");
    waitCycles(1);
    clear = 1'b0;
    clear_mask = 4'h0;
    waitCycles(3);

    // Asynchronous reset during a debounce check, then re-debounce of the held button
    pb_n[1] = 1'b0;
    waitCycles(5);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", port_in, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    n = cyc;
    pushExp(n + LAT - 1, 32'h0000_F022, 32'h0,         "redebounce_early");
    pushExp(n + LAT,     32'h0000_F022, 32'h0000_1022, "redebounce");
    waitCycles(14);
    pb_n[1] = 1'b1;
    waitCycles(14);
  endtask

  initial begin
    int guard;
    $display("[TB] pb_input_port bench start");
    applyStimulus();
    guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      waitCycles(1);
      guard++;
    end
    checkOutput("queue_drain", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
